fc_stream_driver: RTL
=====================

# fc_stream_driver

Initiator/transmitter side of the fc_controller word-stream interface. On a start pulse it reads one complete FC job image (input vector, weight matrix, bias) from a word-wide local memory, converts each word to the wire byte order, and streams it to fc_controller over `r_valid`/`in_data`. It then collects the `t_valid`/`out_data` result words, reassembles them into one result register, and reports done or timeout. It sits between the job memory and fc_controller.

## Interface
- `IN_BYTES`, 8, input vector length in bytes (multiple of 4)
- `OUT_BYTES`, 4, output/bias length in bytes (multiple of 4)
- `AW`, 8, memory word-address width
- `TIMEOUT`, 1024, max idle cycles allowed while waiting for a result word
- Derived: `TX_WORDS = IN_BYTES/4 + IN_BYTES*OUT_BYTES/4 + OUT_BYTES/4` (11 at defaults); `RX_WORDS = OUT_BYTES/4` (1)

- `clk`  in  1  single clock, all logic on posedge
- `rstn`  in  1  reset, synchronous, active-low
- `start`  in  1  job request, sampled only in IDLE
- `base_addr`  in  AW  word address of first image word, captured on start
- `busy`  out  1  high from start acceptance until done
- `done`  out  1  one-cycle pulse at job end (success or timeout)
- `timeout_err`  out  1  sticky; set on timeout, cleared on next accepted start
- `mem_rd_en`  out  1  memory read strobe
- `mem_addr`  out  AW  memory word address
- `mem_rdata`  in  32  read data, valid the cycle after `mem_rd_en` is sampled
- `r_valid`  out  1  stream word valid toward fc_controller
- `in_data`  out  32  stream word, little-endian packed
- `t_valid`  in  1  result word valid from fc_controller
- `out_data`  in  32  result word, little-endian packed
- `res_data`  out  OUT_BYTES*8  reassembled result, element 0 in MSByte
- `res_valid`  out  1  `res_data` valid; cleared on next accepted start

## Operation
- Memory image: TX_WORDS consecutive words from `base_addr`: input words, then weight words, then bias words. Each memory word stores elements big-endian (element 4k in bits [31:24]).
- Wire format: byte swap per word; element 4k+j on `in_data[8j+7:8j]`. Same convention on `out_data`.
- FSM: IDLE -> SEND -> WAIT -> IDLE.
  - IDLE: `start`=1 -> capture `base_addr`, set `busy`, clear `res_valid`, `timeout_err`, `res_data`; go SEND.
  - SEND: issue TX_WORDS reads, one per cycle, ascending addresses; register each returned word (swapped) onto `in_data` with `r_valid`=1. When the last word has left, `r_valid`=0, `in_data`=0, go WAIT.
  - WAIT: each `t_valid` cycle captures `out_data` into result slot k (k = 0..RX_WORDS-1 in arrival order), byte-swapped back to MSByte-first: result element m at `res_data[OUT_BYTES*8-1-8m -: 8]`. After the RX_WORDS-th capture: `res_valid`=1, `done` pulse, `busy`=0, go IDLE.
  - Timeout: WAIT idle-counter resets on entry and on each captured word; reaching TIMEOUT -> `timeout_err`=1, `done` pulse, `busy`=0, `res_valid` stays 0, go IDLE.
- `t_valid` outside WAIT ignored. `start` while busy ignored. `mem_addr` wraps modulo 2^AW.
- `rstn`=0 at any edge, including mid-job: all outputs 0, FSM IDLE, counters 0; no partial stream resumes.

## Timing
- Reset values: `busy`, `done`, `timeout_err`, `mem_rd_en`, `mem_addr`, `r_valid`, `in_data`, `res_data`, `res_valid` all 0.
- Start sampled at edge E0 -> `mem_rd_en`=1, `mem_addr`=base after E0, held high for exactly TX_WORDS cycles (addresses base..base+TX_WORDS-1).
- `r_valid` first high after E2, high for exactly TX_WORDS contiguous cycles (no bubbles), low after E(TX_WORDS+2).
- Result word captured at the edge where `t_valid`=1; final capture edge also registers `res_valid`=1 and `done`=1; `done` low next cycle. Min job latency start→done: TX_WORDS+3 cycles with `t_valid` immediately in WAIT.
- `start` accepted earliest the cycle after `done`.

## Test plan
- Reset: hold `rstn`=0 10 cycles with `start`=1, `t_valid`=1 -> all outputs 0, no memory reads.
- Job 1: memory 0x12102ab4, 0xff1a53bd, weights starting 0x81f01fb8 ..., bias 0xef19f273; stub returns 0x7f0213ec -> `in_data` sequence begins 0xb42a1012, 0xbd531aff, 0xb81ff081, ends 0x73f219ef, 11 contiguous `r_valid` cycles; `res_data`=0xec13027f, `res_valid`=1, one `done` pulse.
- Job 2 back-to-back at `base_addr`=0x20: input 0x0e06f591, 0x292ec321, bias 0xc842c44e; stub returns 0x3480faa6 -> first wire word 0x91f5060e, `res_data`=0xa6fa8034, previous result cleared at start.
- Timeout: stub never asserts `t_valid` -> `done` pulse exactly TIMEOUT cycles after WAIT entry, `timeout_err`=1, `res_valid`=0; next start clears `timeout_err`.
- Protocol abuse: `start` pulsed during SEND, `t_valid` pulsed during SEND and IDLE -> ignored; stream and result unchanged.
- Reset mid-SEND after 5 words -> `r_valid` and `mem_rd_en` drop at next edge, FSM IDLE; fresh job completes correctly.

Source files
------------

// File: rtl/fc_stream_driver.sv
// Initiator side of the fc_controller word stream: reads a job image from local
// memory, streams it byte-swapped, then collects and reassembles the result.
module fc_stream_driver #(
    parameter int IN_BYTES  = 8,
    parameter int OUT_BYTES = 4,
    parameter int AW        = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic                   mem_rd_en,
    output logic [AW-1:0]          mem_addr,
    input  logic [31:0]            mem_rdata,
    output logic                   r_valid,
    output logic [31:0]            in_data,
    input  logic                   t_valid,
    input  logic [31:0]            out_data,
    output logic [OUT_BYTES*8-1:0] res_data,
    output logic                   res_valid
);

    localparam int TX_WORDS = IN_BYTES/4 + IN_BYTES*OUT_BYTES/4 + OUT_BYTES/4;
    localparam int RX_WORDS = OUT_BYTES/4;
    localparam int OUT_BITS = OUT_BYTES*8;
    localparam int TXC_W    = $clog2(TX_WORDS + 1);
    localparam int RXC_W    = $clog2(RX_WORDS + 1);
    localparam int IDLE_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t              state;
    logic [TXC_W-1:0]    rd_cnt;
    logic                rd_pend;
    logic [RXC_W-1:0]    rx_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    // Memory words hold element 4k in the top byte; the wire carries it in the bottom byte.
    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            r_valid     <= 1'b0;
            in_data     <= '0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            rd_cnt      <= '0;
            rd_pend     <= 1'b0;
            rx_cnt      <= '0;
            idle_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SEND;
                        busy        <= 1'b1;
                        res_valid   <= 1'b0;
                        timeout_err <= 1'b0;
                        res_data    <= '0;
                        mem_rd_en   <= 1'b1;
                        mem_addr    <= base_addr;
                        rd_cnt      <= TXC_W'(1);
                        rd_pend     <= 1'b0;
                    end
                end
                SEND: begin
                    // rd_pend marks that mem_rdata holds the word requested last cycle.
                    rd_pend <= mem_rd_en;
                    r_valid <= rd_pend;
                    in_data <= rd_pend ? swap32(mem_rdata) : '0;
                    if (rd_cnt < TXC_W'(TX_WORDS)) begin
                        mem_addr <= mem_addr + 1'b1;
                        rd_cnt   <= rd_cnt + 1'b1;
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                    if (r_valid && !rd_pend) begin
                        state    <= WAIT;
                        idle_cnt <= '0;
                        rx_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (t_valid) begin
                        for (int k = 0; k < RX_WORDS; k++) begin
                            if (rx_cnt == RXC_W'(k)) begin
                                res_data[OUT_BITS-1-32*k -: 32] <= swap32(out_data);
                            end
                        end
                        idle_cnt <= '0;
                        if (rx_cnt == RXC_W'(RX_WORDS - 1)) begin
                            res_valid <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
